// File: rtl/boss_hit_detector.sv
// -----------------------------------------------------------------------------
// boss_hit_detector
//
// Scans the VGA pixel stream for pixels where a player shot overlaps the boss
// sprite. Once per frame it decides whether enough overlap occurred to count as
// a hit. If so, it emits a single-cycle is_hit pulse so the boss logic can
// decrement its life. A cooldown of COOLDOWN_FRAMES frames follows each
// reported hit.
//
// Ports:
//   clk_in      system clock
//   reset       asynchronous, active-high reset
//   x, y        current scan pixel column / row (each pixel held several clocks)
//   boss_on     boss sprite opaque at (x, y)
//   shot_on     any player shot opaque at (x, y)
//   boss_alive  high while boss life != 0
//   is_hit      one-cycle hit pulse, one clock after the frame-end pixel appears
//   hit_count   total hits reported, saturating at 255
//   frame_tick  one-cycle pulse for each detected frame end (aligned with is_hit)
//   ovl_cnt     current-frame overlap count (debug)
// -----------------------------------------------------------------------------
module boss_hit_detector #(
    parameter int MAX_X           = 384,
    parameter int MAX_Y           = 448,
    parameter int MIN_OVERLAP     = 4,
    parameter int COOLDOWN_FRAMES = 2
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        boss_on,
    input  logic        shot_on,
    input  logic        boss_alive,
    output logic        is_hit,
    output logic [7:0]  hit_count,
    output logic        frame_tick,
    output logic [15:0] ovl_cnt
);

    localparam logic [9:0]  MAX_X_L = 10'(MAX_X);
    localparam logic [9:0]  MAX_Y_L = 10'(MAX_Y);
    localparam logic [15:0] MIN_L   = 16'(MIN_OVERLAP);
    localparam logic [7:0]  CD_L    = 8'(COOLDOWN_FRAMES);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        REPORT   = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    state_t      state;
    logic [19:0] px_reg;
    logic [7:0]  cd_cnt;

    logic new_px;
    logic in_field;
    logic counted;
    logic frame_end;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // A pixel is held for several clocks; only its first clock is acted on.
    assign new_px    = ({x, y} != px_reg);
    assign in_field  = (x < MAX_X_L) && (y < MAX_Y_L);
    assign counted   = new_px && in_field && boss_on && shot_on && boss_alive;
    // y == MAX_Y lies outside the playfield, so this never coincides with a counted pixel.
    assign frame_end = new_px && (x == 10'd0) && (y == MAX_Y_L);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state      <= SCAN;
            px_reg     <= {10'h3FF, 10'h3FF};
            ovl_cnt    <= 16'd0;
            hit_count  <= 8'd0;
            cd_cnt     <= 8'd0;
            is_hit     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            px_reg     <= {x, y};
            frame_tick <= frame_end;
            is_hit     <= 1'b0;

            if (!boss_alive) begin
                // A dead boss overrides everything, including a frame-end decision.
                state   <= SCAN;
                ovl_cnt <= 16'd0;
                cd_cnt  <= 8'd0;
            end else begin
                case (state)
                    SCAN: begin
                        if (frame_end) begin
                            if (ovl_cnt >= MIN_L) begin
                                // is_hit is registered, so it is high exactly while in REPORT.
                                state  <= REPORT;
                                is_hit <= 1'b1;
                            end else begin
                                ovl_cnt <= 16'd0;
                            end
                        end else if (counted) begin
                            ovl_cnt <= sat_inc16(ovl_cnt);
                        end
                    end

                    REPORT: begin
                        hit_count <= sat_inc8(hit_count);
                        ovl_cnt   <= 16'd0;
                        cd_cnt    <= CD_L;
                        state     <= (COOLDOWN_FRAMES > 0) ? COOLDOWN : SCAN;
                    end

                    COOLDOWN: begin
                        ovl_cnt <= 16'd0;
                        if (frame_end) begin
                            // <= 1 also recovers from a stray zero count.
                            if (cd_cnt <= 8'd1) begin
                                cd_cnt <= 8'd0;
                                state  <= SCAN;
                            end else begin
                                cd_cnt <= cd_cnt - 8'd1;
                            end
                        end
                    end

                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule

// File: doc/boss_hit_detector.md
Name: boss_hit_detector

Overview:
- Producer side of the boss damage interface: scans the VGA pixel stream and finds pixels where a player shot overlaps the boss sprite.
- Reduces those overlaps to one hit decision per frame and emits a single-cycle is_hit pulse for the boss module to decrement life.
- Applies a minimum-overlap threshold and an invincibility cooldown, and keeps a running hit counter for score/HUD.
- Sits between the player-shot renderer, the boss renderer and the boss life logic.

Parameters:
- MAX_X, 384, playfield width in pixels; pixels with x >= MAX_X are ignored.
- MAX_Y, 448, playfield height; the pixel (0, MAX_Y) marks frame end.
- MIN_OVERLAP, 4, number of overlapping pixels in a frame needed to register a hit.
- COOLDOWN_FRAMES, 2, frames ignored after a reported hit; 0 disables cooldown.

Ports:
- clk_in  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- x  input  10  current scan pixel column
- y  input  10  current scan pixel row
- boss_on  input  1  boss sprite opaque at (x, y)
- shot_on  input  1  any player shot opaque at (x, y)
- boss_alive  input  1  high while boss life != 0
- is_hit  output  1  one-cycle hit pulse to the boss
- hit_count  output  8  total hits reported, saturating
- frame_tick  output  1  one-cycle pulse at each detected frame end
- ovl_cnt  output  16  current-frame overlap count (debug)

Behaviour:
- Clock domain and reset: reset is asynchronous, active-high; all state is clocked on clk_in.
- Reset values:
  - state = SCAN, ovl_cnt = 0, hit_count = 0, cd_cnt = 0, is_hit = 0, frame_tick = 0.
  - px_reg = {10'h3FF, 10'h3FF}, so the first sampled pixel is treated as new.
- Pixel sampling:
  - Each pixel is held for several clk_in cycles. px_reg registers {x, y} every cycle.
  - new_px = ({x, y} != px_reg). Counting and frame-end detection act only on cycles where new_px = 1.
  - Result: each pixel is counted exactly once, regardless of how many clocks it is held.
- Counted pixel: new_px && x < MAX_X && y < MAX_Y && boss_on && shot_on && boss_alive.
- Frame end: new_px && x == 0 && y == MAX_Y.
  - frame_tick is asserted for that one cycle in every state.
- FSM:
  - SCAN:
    - On a counted pixel, ovl_cnt += 1, saturating at 16'hFFFF.
    - At frame end with ovl_cnt >= MIN_OVERLAP: go to REPORT.
    - At frame end otherwise: clear ovl_cnt and stay in SCAN.
  - REPORT (exactly 1 cycle):
    - is_hit = 1 (registered output, high only in this cycle).
    - hit_count += 1, saturating at 255.
    - ovl_cnt = 0, cd_cnt = COOLDOWN_FRAMES.
    - Next state is COOLDOWN if COOLDOWN_FRAMES > 0, else SCAN.
  - COOLDOWN:
    - Counted pixels are ignored; ovl_cnt stays 0.
    - At each frame end, cd_cnt -= 1. When the decrement makes cd_cnt 0, go to SCAN.
    - Counting resumes with the first pixel after that frame end.
- Latency: is_hit rises on the clk_in cycle after the frame-end cycle, so 1 cycle after (0, MAX_Y) first appears.
- Boundary conditions:
  - boss_alive low in any state: next state is SCAN, ovl_cnt = 0, cd_cnt = 0, no pulse. This takes priority over the frame-end decision in the same cycle.
  - A counted pixel and frame end cannot occur in the same cycle, because y == MAX_Y is outside the playfield.
  - x/y glitches that revisit a pixel are recounted; the upstream scan generator guarantees a monotonic scan.
  - Reset mid-REPORT or mid-COOLDOWN: immediate return to reset values; no residual pulse.
- is_hit and frame_tick are never high for more than one consecutive cycle.

Test Plan:
- Reset asserted mid-frame, then released -> all outputs 0; state SCAN on the next pixel.
- One frame with 10 overlapping pixels, each held 4 clocks, boss_alive = 1 -> ovl_cnt = 10 (not 40) before frame end; is_hit high for exactly 1 cycle, 1 cycle after (0, 448); hit_count = 1; ovl_cnt = 0.
- A frame with 3 overlaps (MIN_OVERLAP = 4) -> frame_tick pulses, is_hit stays 0, ovl_cnt returns to 0, hit_count unchanged.
- Four consecutive frames with 10 overlaps each, COOLDOWN_FRAMES = 2:
  - is_hit pulses at the end of frame 1.
  - No pulse at the end of frames 2 and 3.
  - is_hit pulses at the end of frame 4.
  - hit_count = 2.
- Overlaps only at x = 400, or with boss_alive = 0 -> ovl_cnt stays 0 and no is_hit. boss_alive dropping during COOLDOWN -> state SCAN, cd_cnt = 0.
- Force 260 hit frames with COOLDOWN_FRAMES = 0 -> hit_count saturates at 255; is_hit still pulses once per hit frame.
